// File: rtl/dip_debounce_reader.sv
// Debounces a bank of DIP switches by sampling on a slow tick and requiring a run of equal samples.
// The first qualified value becomes the baseline; later qualified changes raise a held event.
module dip_debounce_reader #(
    parameter int DIP_W        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIP_W-1:0] dips_in,
    output logic [DIP_W-1:0] dips_stable,
    output logic             init_done,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [DIP_W-1:0] evt_data,
    output logic [DIP_W-1:0] evt_diff,
    output logic             evt_ovf,
    input  logic             ovf_clr
);

    // state  | meaning
    // S_INIT | waiting for the first value to qualify (baseline, no event)
    // S_IDLE | debounced value settled, watching for a differing sample
    // S_QUAL | a differing sample was seen, waiting for a run to qualify
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_QUAL} state_t;

    localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MATCH_W = $clog2(STABLE_TICKS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_TICKS);
    localparam logic [MATCH_W-1:0] MATCH_PRE = MATCH_W'(STABLE_TICKS - 1);

    state_t             state, state_next;
    logic [DIP_W-1:0]   sync1, sync2;
    logic [DIP_W-1:0]   cand;
    logic [DIP_W-1:0]   ref_val;
    logic [TICK_W-1:0]  tick_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic               tick, samp_differs, qual, accept;
    logic               load_base, new_evt;

    assign tick         = (tick_cnt == TICK_LAST);
    assign samp_differs = (sync2 != cand);
    assign qual         = tick && !samp_differs && (match_cnt == MATCH_PRE);
    assign accept       = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dips_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            match_cnt <= '0;
        end else if (tick) begin
            if (samp_differs) begin
                cand      <= sync2;
                match_cnt <= MATCH_W'(1);
            end else if (match_cnt != MATCH_MAX) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_base  = 1'b0;
        new_evt    = 1'b0;
        case (state)
            S_INIT: begin
                if (qual) begin
                    load_base  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (tick && (sync2 != dips_stable)) begin
                    state_next = S_QUAL;
                end
            end
            S_QUAL: begin
                if (qual) begin
                    new_evt    = (cand != dips_stable);
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    // ref_val is the last value the consumer has seen (baseline or accepted event)
    always_ff @(posedge clk) begin
        if (rst) begin
            dips_stable <= '0;
            init_done   <= 1'b0;
            ref_val     <= '0;
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_diff    <= '0;
            evt_ovf     <= 1'b0;
        end else begin
            if (load_base || new_evt) begin
                dips_stable <= cand;
            end
            if (load_base) begin
                init_done <= 1'b1;
                ref_val   <= cand;
            end else if (accept) begin
                ref_val <= evt_data;
            end
            if (new_evt) begin
                evt_valid <= 1'b1;
                evt_data  <= cand;
                evt_diff  <= cand ^ (accept ? evt_data : ref_val);
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
            if (new_evt && evt_valid && !evt_ready) begin
                evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dip_debounce_reader.sv
// Bench for dip_debounce_reader: directed scenarios plus random traffic, all compared
// against a tick-level reference model that qualifies a value by its run length.
module tb_dip_debounce_reader;

    localparam int DIP_W        = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic             clk;
    logic             rst;
    logic [DIP_W-1:0] dips_in;
    logic [DIP_W-1:0] dips_stable;
    logic             init_done;
    logic             evt_valid;
    logic             evt_ready;
    logic [DIP_W-1:0] evt_data;
    logic [DIP_W-1:0] evt_diff;
    logic             evt_ovf;
    logic             ovf_clr;

    dip_debounce_reader #(
        .DIP_W(DIP_W),
        .TICK_DIV(TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dips_in(dips_in),
        .dips_stable(dips_stable),
        .init_done(init_done),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_data(evt_data),
        .evt_diff(evt_diff),
        .evt_ovf(evt_ovf),
        .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int saw_valid = 0;

    // reference model state
    int               m_e;
    logic [DIP_W-1:0] m_dly0, m_dly1;
    logic [DIP_W-1:0] samp_q[$];
    logic [DIP_W-1:0] m_stable, m_data, m_diff, m_ref, m_v;
    logic             m_init, m_valid, m_ovf;
    bit               m_qual, m_accept, m_new, m_set_ovf;
    int               m_run;

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0; m_dly0 = '0; m_dly1 = '0; samp_q.delete();
            m_stable = '0; m_data = '0; m_diff = '0; m_ref = '0;
            m_init = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            m_qual = 1'b0;
            m_v = m_dly1;
            if (m_e % TICK_DIV == TICK_DIV - 1) begin
                samp_q.push_back(m_v);
                if (samp_q.size() > STABLE_TICKS + 1) void'(samp_q.pop_front());
                m_run = 0;
                for (int i = samp_q.size() - 1; i >= 0; i--) begin
                    if (samp_q[i] != m_v) break;
                    m_run++;
                end
                m_qual = (m_run == STABLE_TICKS);
            end
            m_accept  = m_valid && evt_ready;
            m_new     = m_qual && m_init && (m_v != m_stable);
            m_set_ovf = m_new && m_valid && !evt_ready;
            if (m_qual && !m_init) begin
                m_init = 1'b1; m_stable = m_v; m_ref = m_v;
            end
            if (m_new) begin
                m_diff = m_v ^ (m_accept ? m_data : m_ref);
                if (m_accept) m_ref = m_data;
                m_data = m_v; m_valid = 1'b1; m_stable = m_v;
            end else if (m_accept) begin
                m_ref = m_data; m_valid = 1'b0;
            end
            if (m_set_ovf) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_dly1 = m_dly0;
            m_dly0 = dips_in;
            m_e++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_stable", 32'(dips_stable), 32'(m_stable));
        chk("m_init",   32'(init_done),   32'(m_init));
        chk("m_valid",  32'(evt_valid),   32'(m_valid));
        chk("m_data",   32'(evt_data),    32'(m_data));
        chk("m_diff",   32'(evt_diff),    32'(m_diff));
        chk("m_ovf",    32'(evt_ovf),     32'(m_ovf));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (evt_valid) saw_valid++;
            check_model();
        end
    endtask

    initial begin
        bit got;
        rst = 1'b1; dips_in = 4'b1010; evt_ready = 1'b1; ovf_clr = 1'b0;
        step(2);
        chk("rst_init",   32'(init_done),   32'd0);
        chk("rst_valid",  32'(evt_valid),   32'd0);
        chk("rst_stable", 32'(dips_stable), 32'd0);

        // baseline
        rst = 1'b0; saw_valid = 0;
        step(14);
        chk("base_init",   32'(init_done),   32'd1);
        chk("base_stable", 32'(dips_stable), 32'b1010);
        chk("base_noevt",  32'(saw_valid),   32'd0);

        // single change accepted immediately
        dips_in = 4'b1011;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step(1);
            got = evt_valid;
        end
        chk("chg_seen", 32'(got), 32'd1);
        chk("chg_data", 32'(evt_data), 32'b1011);
        chk("chg_diff", 32'(evt_diff), 32'b0001);
        step(1);
        chk("chg_onecycle", 32'(evt_valid), 32'd0);

        // glitch rejection around baseline 1010
        dips_in = 4'b1010;
        step(30);
        saw_valid = 0;
        dips_in = 4'b1110;
        step(5);
        dips_in = 4'b1010;
        step(30);
        chk("glitch_stable", 32'(dips_stable), 32'b1010);
        chk("glitch_noevt",  32'(saw_valid),   32'd0);

        // overwrite with back-pressure
        rst = 1'b1; dips_in = 4'b0000; evt_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(20);
        dips_in = 4'b0001;
        step(20);
        dips_in = 4'b0011;
        step(20);
        chk("ovw_data",  32'(evt_data), 32'b0011);
        chk("ovw_diff",  32'(evt_diff), 32'b0011);
        chk("ovw_ovf",   32'(evt_ovf),  32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(evt_ovf), 32'd0);

        // back-pressure hold
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("bp_valid",  32'(evt_valid),   32'd1);
            chk("bp_data",   32'(evt_data),    32'b0011);
            chk("bp_diff",   32'(evt_diff),    32'b0011);
            chk("bp_stable", 32'(dips_stable), 32'b0011);
        end
        evt_ready = 1'b1;
        step(1);
        chk("bp_release", 32'(evt_valid), 32'd0);

        // reset while qualifying with an event pending
        evt_ready = 1'b0;
        dips_in = 4'b0111;
        step(20);
        chk("mid_pending", 32'(evt_valid), 32'd1);
        dips_in = 4'b1111;
        step(6);
        rst = 1'b1;
        step(1);
        chk("mid_rst_valid",  32'(evt_valid),   32'd0);
        chk("mid_rst_stable", 32'(dips_stable), 32'd0);
        chk("mid_rst_init",   32'(init_done),   32'd0);
        chk("mid_rst_ovf",    32'(evt_ovf),     32'd0);
        rst = 1'b0; saw_valid = 0;
        step(20);
        chk("rebase_init",   32'(init_done),   32'd1);
        chk("rebase_stable", 32'(dips_stable), 32'b1111);
        chk("rebase_noevt",  32'(saw_valid),   32'd0);

        // random traffic
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 24) == 0) dips_in = DIP_W'($urandom);
            evt_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dip_debounce_reader.md
DIP_DEBOUNCE_READER -- requirements
Module: dip_debounce_reader

Interface
REQ-001 SHALL have parameter DIP_W, default 4, number of DIP switch inputs.
REQ-002 SHALL have parameter TICK_DIV, default 50000, clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE_TICKS, default 8, consecutive equal samples needed to qualify (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port dips_in  in  DIP_W  raw asynchronous switch levels.
REQ-007 SHALL have port dips_stable  out  DIP_W  debounced switch value.
REQ-008 SHALL have port init_done  out  1  high once the first value has qualified.
REQ-009 SHALL have port evt_valid  out  1  change event pending.
REQ-010 SHALL have port evt_ready  in  1  consumer accepts event.
REQ-011 SHALL have port evt_data  out  DIP_W  new debounced value carried by the event.
REQ-012 SHALL have port evt_diff  out  DIP_W  bits changed since the last accepted or baseline value.
REQ-013 SHALL have port evt_ovf  out  1  sticky flag: event overwritten before acceptance.
REQ-014 SHALL have port ovf_clr  in  1  clears evt_ovf.

Function
REQ-015 SHALL pass dips_in through a 2-flop synchronizer; only the second stage (sync) is used.
REQ-016 SHALL run a tick counter 0..TICK_DIV-1 that wraps, asserting a one-cycle tick when the count equals TICK_DIV-1.
REQ-017 SHALL, on each tick: if sync differs from the candidate register, load the candidate and set the match count to 1; else increment the match count, saturating at STABLE_TICKS.
REQ-018 SHALL declare qualification on the tick where the match count reaches STABLE_TICKS.
REQ-019 SHALL implement FSM states S_INIT, S_IDLE and S_QUAL.
REQ-020 SHALL, in S_INIT, on qualification load dips_stable, set init_done, go to S_IDLE, and raise no event; this value is the baseline.
REQ-021 SHALL, in S_IDLE, go to S_QUAL on a tick whose sample differs from dips_stable.
REQ-022 SHALL, in S_QUAL, on qualification with candidate != dips_stable, update dips_stable and raise an event, then go to S_IDLE.
REQ-023 SHALL, in S_QUAL, return to S_IDLE without event when the candidate reverts to dips_stable and qualifies (glitch rejected).
REQ-024 SHALL update dips_stable and evt_valid on the same clock edge; evt_data SHALL equal the new dips_stable.
REQ-025 SHALL hold evt_valid, evt_data and evt_diff unchanged until the cycle where evt_valid and evt_ready are both high; evt_valid drops on the following edge.
REQ-026 SHALL, on a new event while one is pending and not accepted, overwrite evt_data, set evt_diff to the new value XOR the last accepted or baseline value, keep evt_valid high, and set evt_ovf.
REQ-027 SHALL, when acceptance and a new event coincide, load the new event with evt_valid kept high, base evt_diff on the just-accepted evt_data, and leave evt_ovf unchanged.
REQ-028 SHALL clear evt_ovf on ovf_clr; a set and a clear in the same cycle SHALL leave evt_ovf set.
REQ-029 SHALL ignore evt_ready when evt_valid is low.
REQ-030 SHALL bound worst-case latency from a clean dips_in step to dips_stable at 2 + STABLE_TICKS*TICK_DIV cycles.

Reset
REQ-031 SHALL, on rst, reset synchronizer, candidate, tick and match counters to 0, FSM to S_INIT, and dips_stable, evt_data and evt_diff to 0.
REQ-032 SHALL, on rst, drive init_done, evt_valid and evt_ovf to 0.
REQ-033 SHALL, when rst is asserted mid-qualification or with an event pending, discard both with no event emitted.
REQ-034 SHALL, after reset is released, re-baseline through S_INIT.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-035 SHALL cover baseline: reset, dips_in=4'b1010 held -> init_done=1 and dips_stable=1010 within 14 cycles, evt_valid stays 0.
REQ-036 SHALL cover change: baseline 1010, step to 1011, evt_ready=1 -> evt_valid one cycle, evt_data=1011, evt_diff=0001.
REQ-037 SHALL cover glitch: baseline 1010, 1110 for 5 cycles then back -> no event, dips_stable stays 1010.
REQ-038 SHALL cover overwrite: evt_ready=0, baseline 0000 then 0001 then 0011 -> evt_data=0011, evt_diff=0011, evt_ovf=1; ovf_clr pulse -> evt_ovf=0.
REQ-039 SHALL cover back-pressure: evt_ready held low 50 cycles with stable input -> outputs constant; evt_ready=1 -> evt_valid low next cycle.
REQ-040 SHALL cover reset mid-operation: rst during S_QUAL with an event pending -> all outputs 0 next cycle, then re-baseline with no event.
